// File: rtl/scan_capture_bcd.sv
// Rebuilds four parallel BCD digits from a time-multiplexed scan stream.
// A select must dwell before its digit is taken; outputs move only after repeated identical frames.
module scan_capture_bcd #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [3:0] digito_in,
  input  logic [1:0] sel_in,
  output logic [3:0] digito0,
  output logic [3:0] digito1,
  output logic [3:0] digito2,
  output logic [3:0] digito3,
  output logic       valid,
  output logic       frame_done,
  output logic       bcd_err
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [2:0] STABLE = 3'(STABLE_FRAMES);

  logic [1:0]      sel_prev_q, sel_prev_d;
  logic [3:0]      dwell_q, dwell_d;
  logic [3:0]      seen_q, seen_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0][3:0] prev_q, prev_d;
  logic [2:0]      match_q, match_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            sample;

  function automatic logic [3:0] sat_dwell(input logic [3:0] d);
    return (d >= SETTLE) ? SETTLE : d + 4'd1;
  endfunction

  function automatic logic [2:0] sat_match(input logic [2:0] m);
    return (m >= STABLE) ? STABLE : m + 3'd1;
  endfunction

  always_comb begin
    sel_prev_d = sel_prev_q;
    dwell_d    = dwell_q;
    seen_d     = seen_q;
    shadow_d   = shadow_q;
    prev_d     = prev_q;
    match_d    = match_q;
    dig_d      = dig_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sample     = 1'b0;

    if (scan_en) begin
      // A frame completed on the previous qualified edge is judged against the last frame here.
      if (seen_q == 4'hF) begin
        done_d = 1'b1;
        seen_d = 4'h0;
        prev_d = shadow_q;
        if ((shadow_q == prev_q) && (match_q != 3'd0)) match_d = sat_match(match_q);
        else                                            match_d = 3'd1;
        if (match_d == STABLE) begin
          dig_d   = shadow_q;
          valid_d = 1'b1;
        end
      end

      if (sel_in != sel_prev_q) begin
        sel_prev_d = sel_in;
        dwell_d    = 4'd1;
        sample     = (SETTLE == 4'd1);
      end else begin
        dwell_d = sat_dwell(dwell_q);
        sample  = (dwell_q != SETTLE) && (dwell_d == SETTLE);
      end

      // A non-BCD sample discards the partial frame and the match history.
      if (sample) begin
        if (digito_in > 4'd9) begin
          err_d   = 1'b1;
          seen_d  = 4'h0;
          match_d = 3'd0;
        end else begin
          shadow_d[sel_in] = digito_in;
          seen_d[sel_in]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_prev_q <= '0;
      dwell_q    <= '0;
      seen_q     <= '0;
      shadow_q   <= '0;
      prev_q     <= '0;
      match_q    <= '0;
      dig_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sel_prev_q <= sel_prev_d;
      dwell_q    <= dwell_d;
      seen_q     <= seen_d;
      shadow_q   <= shadow_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      dig_q      <= dig_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign digito0    = dig_q[0];
  assign digito1    = dig_q[1];
  assign digito2    = dig_q[2];
  assign digito3    = dig_q[3];
  assign valid      = valid_q;
  assign frame_done = done_q;
  assign bcd_err    = err_q;

endmodule

// File: doc/scan_capture_bcd.md
Name: scan_capture_bcd

Overview:
- Receiving end of the 4-digit time-multiplexed BCD display interface.
- Samples a scanned stream (one 4-bit digit plus a 2-bit position select) and rebuilds the four parallel BCD digits.
- Rejects select glitches and non-BCD codes, and only updates its outputs after consecutive identical frames.
- Sits between an external or internal multiplexed digit source and downstream BCD/binary conversion logic.

Parameters:
- SETTLE_CYCLES, 4: consecutive qualified cycles a select value must dwell before its digit is sampled. Range 1..15.
- STABLE_FRAMES, 2: consecutive identical complete frames required before the outputs update. Range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- scan_en  input  1  qualifies digito_in/sel_in this cycle; low freezes all internal state.
- digito_in  input  4  scanned BCD digit.
- sel_in  input  2  position of digito_in: 0 = rightmost, 3 = leftmost.
- digito0  output  4  reconstructed digit, position 0.
- digito1  output  4  reconstructed digit, position 1.
- digito2  output  4  reconstructed digit, position 2.
- digito3  output  4  reconstructed digit, position 3.
- valid  output  1  high once outputs hold a confirmed frame; sticky until reset.
- frame_done  output  1  one-cycle pulse per completed, error-free frame.
- bcd_err  output  1  one-cycle pulse when a sampled digit is greater than 9.

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous, active-low. While rst_n = 0, every output, register, sel_prev, dwell counter, seen mask, shadow/prev-frame registers and match counter is 0.
- Dwell counting, on qualified cycles (scan_en = 1) only:
  - sel_in != sel_prev: sel_prev <= sel_in and dwell <= 1.
  - Otherwise: dwell increments, saturating at SETTLE_CYCLES.
- Sample: on the qualified edge where dwell becomes exactly SETTLE_CYCLES, shadow[sel_in] <= digito_in and seen[sel_in] <= 1.
  - With SETTLE_CYCLES = 1, the first qualified cycle of each new select samples.
  - Exactly one sample per dwell. Re-visiting a position within a frame overwrites it (latest wins).
- A select change on the would-be sample cycle restarts dwell; no sample is taken.
- Non-BCD: a sample with digito_in > 9 does the following:
  - pulses bcd_err the next cycle;
  - clears seen and sets match_cnt <= 0;
  - leaves prev_frame and the outputs unchanged.
- Frame complete (seen = 4'b1111), evaluated the cycle after the completing sample:
  - frame_done pulses and seen clears.
  - If shadow == prev_frame and match_cnt > 0: match_cnt increments, saturating at STABLE_FRAMES. Otherwise match_cnt <= 1.
  - prev_frame <= shadow.
  - When the new match_cnt equals STABLE_FRAMES, digito0..3 <= shadow and valid <= 1, in the same cycle as frame_done.
- Latency: outputs update 1 cycle after the edge that samples the last digit of the STABLE_FRAMES-th matching frame.
- scan_en = 0: dwell, seen, shadow and match_cnt hold; outputs hold. Dwell resumes counting when scan_en returns.
- Outputs change only on frame confirmation or reset; they are glitch-free registers.
- Reset mid-frame: everything clears immediately (asynchronous). The first post-reset confirmation again needs STABLE_FRAMES full frames.
- Scan order is free: any order covering all four positions completes a frame.

Test Plan (defaults: SETTLE_CYCLES = 4, STABLE_FRAMES = 2):
- Reset: hold rst_n = 0 with random inputs -> digito0..3 = 0, valid = 0, no pulses.
- Scan positions 0..3 with digits 1,2,3,4, 6 qualified cycles each, two frames:
  - after frame 1: frame_done pulses, valid = 0;
  - after frame 2: digito0..3 = 1,2,3,4 and valid = 1, both coinciding with frame_done.
- Continue scanning with position 2 = 7:
  - frame 3: outputs stay 1,2,3,4;
  - frame 4 identical: digito2 = 7, other outputs unchanged.
- Glitch: position 1 dwells only 3 cycles inside a frame -> no sample, seen[1] stays 0, no frame_done until position 1 dwells 4+ cycles.
- Non-BCD: digit 0xB at position 1 -> bcd_err single pulse, no frame_done for that frame, outputs held; two following clean frames 5,6,7,8 -> outputs 5,6,7,8.
- Async reset and freeze:
  - rst_n pulse mid-frame -> outputs 0 immediately, valid = 0.
  - scan_en low for 20 cycles in mid-dwell -> no sample; the sample occurs after 4 total qualified cycles.
